// File: rtl/mesh_pkg.sv
// Shared mesh geometry constants and the contour scanner state encoding.
// These constants are also used by the twobit_26x18_mesh wrappers.
package mesh_pkg;

    localparam int MESH_COLS   = 26;
    localparam int MESH_ROWS   = 18;
    localparam int MESH_CELL_W = 4;
    localparam int MESH_CELLS  = MESH_COLS * MESH_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } contour_state_t;

endpackage

// File: rtl/contour_row.sv
// Combinational contour of one mesh row. A bit is cleared when its cell is
// inactive and at least one horizontal neighbour (wrapping in the row) is active.
module contour_row
    import mesh_pkg::*;
#(
    parameter int COLS   = MESH_COLS,
    parameter int CELL_W = MESH_CELL_W
) (
    input  logic [COLS*CELL_W-1:0] row_i,
    output logic [COLS-1:0]        contour_o
);

    logic [COLS-1:0] act;

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        localparam int WEST = (c == 0) ? COLS - 1 : c - 1;
        localparam int EAST = (c == COLS - 1) ? 0 : c + 1;

        assign act[c]       = &row_i[c*CELL_W +: CELL_W];
        assign contour_o[c] = act[c] | ~(act[WEST] | act[EAST]);
    end

endmodule

// File: rtl/mesh_contour_extract.sv
// Captures one mesh snapshot and writes its contour map one row per clock,
// holding the finished map stable until the next accepted start.
module mesh_contour_extract
    import mesh_pkg::*;
#(
    parameter int COLS   = MESH_COLS,
    parameter int ROWS   = MESH_ROWS,
    parameter int CELL_W = MESH_CELL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ROWS*COLS*CELL_W-1:0]   mesh_in,
    output logic                          busy,
    output logic                          done,
    output logic [ROWS*COLS-1:0]          contour
);

    localparam int ROW_W    = $clog2(ROWS);
    localparam int ROW_BITS = COLS * CELL_W;

    contour_state_t                      state_q, state_d;
    logic [ROW_W-1:0]                    row_q, row_d;
    logic [ROWS*COLS*CELL_W-1:0]         mesh_q, mesh_d;
    logic [ROWS*COLS-1:0]                contour_q, contour_d;

    logic [ROW_BITS-1:0]                 mesh_rows [ROWS];
    logic [COLS-1:0]                     row_contour;

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign mesh_rows[r] = mesh_q[r*ROW_BITS +: ROW_BITS];
    end

    contour_row #(
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_row (
        .row_i     (mesh_rows[row_q]),
        .contour_o (row_contour)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        mesh_d    = mesh_q;
        contour_d = contour_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    mesh_d    = mesh_in;
                    contour_d = '1;
                    row_d     = '0;
                end
            end
            SCAN: begin
                // Constant-index write per row keeps the slice select static.
                for (int r = 0; r < ROWS; r++) begin
                    if (row_q == ROW_W'(r)) begin
                        contour_d[r*COLS +: COLS] = row_contour;
                    end
                end
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            mesh_q    <= '0;
            contour_q <= '1;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            mesh_q    <= mesh_d;
            contour_q <= contour_d;
        end
    end

    assign busy    = (state_q == SCAN);
    assign done    = (state_q == DONE);
    assign contour = contour_q;

endmodule

// File: tb/tb_mesh_contour_extract.sv
// Self-checking bench: a frame-level contour model plus a timeline of rows
// written since start, compared against the DUT every cycle, with literal pins.
module tb_mesh_contour_extract;

    localparam int C  = 26;
    localparam int R  = 18;
    localparam int W  = 4;
    localparam int N  = R * C;
    localparam int MB = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MB-1:0] mesh_in;
    logic          busy;
    logic          done;
    logic [N-1:0]  contour;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    mesh_contour_extract dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mesh_in (mesh_in),
        .busy    (busy),
        .done    (done),
        .contour (contour)
    );

    always #5 clk = ~clk;

    function automatic bit cell_active(input logic [MB-1:0] m, input int i);
        logic [MB-1:0] t;
        t = m >> (i * W);
        return (t[3:0] == 4'hF);
    endfunction

    function automatic logic [N-1:0] model_contour(input logic [MB-1:0] m);
        logic [N-1:0] res;
        bit a [N];
        int rr, cc, wi, ei;
        for (int i = 0; i < N; i++) a[i] = cell_active(m, i);
        for (int i = 0; i < N; i++) begin
            rr = i / C;
            cc = i % C;
            wi = rr * C + (cc + C - 1) % C;
            ei = rr * C + (cc + 1) % C;
            res[i] = a[i] || !(a[wi] || a[ei]);
        end
        return res;
    endfunction

    function automatic logic [MB-1:0] make_frame(input int kind);
        logic [MB-1:0] m;
        bit on;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (kind == 0) on = (((i / C) + (i % C)) % 2) == 0;
            else           on = (((i % C) / 3) % 2) == 0;
            m = m | (MB'(on ? 4'hF : ((kind == 0) ? 4'h3 : 4'hE)) << (i * W));
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference timeline: k counts edges since the accepted start.
    bit           m_act  = 1'b0;
    int           m_k    = 0;
    logic [N-1:0] m_final = '1;
    logic [N-1:0] m_hold  = '1;

    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_k    <= 0;
            m_hold <= '1;
        end else if (m_act) begin
            if (m_k == R) begin
                m_act  <= 1'b0;
                m_hold <= m_final;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (start) begin
            m_act   <= 1'b1;
            m_k     <= 0;
            m_final <= model_contour(mesh_in);
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_c;
        if (cmp_en) begin
            if (m_act) begin
                for (int i = 0; i < N; i++) exp_c[i] = ((i / C) < m_k) ? m_final[i] : 1'b1;
            end else begin
                exp_c = m_hold;
            end
            chk("busy",    N'(busy),    N'(m_act && (m_k < R)));
            chk("done",    N'(done),    N'(m_act && (m_k == R)));
            chk("contour", contour,     exp_c);
        end
    end

    task automatic run_frame(input logic [MB-1:0] m, input int pulse_at,
                             output int lat, output int nbusy);
        @(negedge clk);
        mesh_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mesh_in = '0;
        lat     = 0;
        nbusy   = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start = (lat == pulse_at);
            if (busy) nbusy++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, nb, ndone;
        logic [MB-1:0] m;
        logic [N-1:0]  lit;

        rst     = 1'b1;
        start   = 1'b0;
        mesh_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_contour", contour, '1);
        chk("reset_busy", N'(busy), '0);
        chk("reset_done", N'(done), '0);

        repeat (30) @(negedge clk);
        chk("idle_contour", contour, '1);

        // Model pins against hand-derived literals.
        lit = '1; lit[4] = 1'b0; lit[6] = 1'b0;
        chk("model_single", model_contour(MB'(4'hF) << 20), lit);
        lit = '1; lit[53] = 1'b0; lit[77] = 1'b0;
        chk("model_wrap", model_contour(MB'(4'hF) << (52 * W)), lit);

        run_frame('0, 0, lat, nb);
        chk("zero_latency", N'(lat), N'(19));
        chk("zero_busy_cycles", N'(nb), N'(18));
        chk("zero_contour", contour, '1);

        run_frame('1, 0, lat, nb);
        chk("ones_latency", N'(lat), N'(19));
        chk("ones_contour", contour, '1);

        run_frame(MB'(4'hF) << 20, 0, lat, nb);
        lit = '1; lit[4] = 1'b0; lit[6] = 1'b0;
        chk("single_contour", contour, lit);

        run_frame(MB'(4'hE) << 20, 0, lat, nb);
        chk("single_1110_contour", contour, '1);

        run_frame(MB'(4'hF) << (52 * W), 0, lat, nb);
        lit = '1; lit[53] = 1'b0; lit[77] = 1'b0;
        chk("wrap_contour", contour, lit);
        chk("wrap_row1_bit51", N'(contour[51]), N'(1'b1));

        for (int f = 0; f < 4; f++) begin
            run_frame(make_frame(f % 2), 0, lat, nb);
            chk("alt_latency", N'(lat), N'(19));
            if ((f % 2) == 0) begin
                for (int i = 0; i < N; i++) lit[i] = (((i / C) + (i % C)) % 2) == 0;
                chk("checker_contour", contour, lit);
            end
        end

        run_frame(make_frame(1), 5, lat, nb);
        chk("start_in_scan_latency", N'(lat), N'(19));

        m = make_frame(0);
        @(negedge clk);
        mesh_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", N'(busy), '0);
        chk("abort_contour", contour, '1);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", N'(ndone), '0);

        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        mesh_in = m;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        ndone = 0;
        nb    = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nb++;
        end
        chk("rst_start_busy", N'(nb), '0);
        chk("rst_start_no_done", N'(ndone), '0);
        chk("rst_start_contour", contour, '1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
